alu_exec_unit: RTL



---
 rtl/alu_exec_unit_if.sv | 23 ++
 rtl/alu_exec_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// Execute-stage ALU bundle: decode-side operands in, result/flags/stall status out.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;
  logic             busy;
  logic             done;

  modport master (
    output valid_i, ALUControl, SrcA, SrcB,
    input  Result, ALUFlags, busy, done
  );

  modport slave (
    input  valid_i, ALUControl, SrcA, SrcB,
    output Result, ALUFlags, busy, done
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/ORR/MOV plus iterative MOD (restoring division)
// and EXP (square-and-multiply), both with fixed WIDTH-cycle run time and a pipeline stall.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StModRun, StExpRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_rem, r_acc, r_res;
  logic [CntW-1:0]  r_cnt;
  logic             r_done;

  // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
  logic             w_is_sub, w_is_mod, w_is_exp;
  logic [WIDTH-1:0] w_b_eff, w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_c, w_v;

  assign w_is_sub = (bus.ALUControl == 3'b001);
  assign w_is_mod = (bus.ALUControl == 3'b101);
  assign w_is_exp = (bus.ALUControl == 3'b110);
  assign w_b_eff  = w_is_sub ? ~bus.SrcB : bus.SrcB;
  assign w_sum    = {1'b0, bus.SrcA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.ALUControl)
      3'b000, 3'b001: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.SrcA[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      3'b010:  w_res = bus.SrcA & bus.SrcB;
      3'b011:  w_res = bus.SrcA | bus.SrcB;
      3'b100:  w_res = bus.SrcB;
      default: w_res = '0;
    endcase
  end

  // One restoring-division step; the shifted remainder needs an extra bit when B > 2^(WIDTH-1).
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_diff, w_rem_next;
  assign w_rem_sh   = {r_rem, r_a[r_cnt]};
  assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_rem_next = (w_rem_sh >= {1'b0, r_b}) ? w_rem_diff : w_rem_sh[WIDTH-1:0];

  // One square-and-multiply step, both products truncated to WIDTH bits.
  logic [WIDTH-1:0] w_sq, w_acc_next;
  assign w_sq       = r_acc * r_acc;
  assign w_acc_next = r_b[r_cnt] ? w_sq * r_a : w_sq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.valid_i && (w_is_mod || w_is_exp)) begin
            r_a     <= bus.SrcA;
            r_b     <= bus.SrcB;
            r_rem   <= '0;
            r_acc   <= WIDTH'(1);
            r_cnt   <= CntMax;
            r_state <= w_is_mod ? StModRun : StExpRun;
          end
        end
        StModRun: begin
          r_rem <= w_rem_next;
          if (r_cnt == '0) begin
            r_res   <= (r_b == '0) ? r_a : w_rem_next;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StExpRun: begin
          r_acc <= w_acc_next;
          if (r_cnt == '0) begin
            r_res   <= w_acc_next;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Busy covers the issue cycle combinationally so decode stalls before the FSM leaves idle.
  assign bus.busy = !rst &&
                    ((r_state == StIdle && bus.valid_i && (w_is_mod || w_is_exp)) ||
                     r_state == StModRun || r_state == StExpRun);
  assign bus.done = r_done && !rst;

  always_comb begin
    bus.Result   = '0;
    bus.ALUFlags = '0;
    if (!rst) begin
      if (r_state == StDone) begin
        bus.Result   = r_res;
        bus.ALUFlags = {r_res[WIDTH-1], r_res == '0, 2'b00};
      end else if (r_state == StIdle) begin
        bus.Result   = w_res;
        bus.ALUFlags = {w_res[WIDTH-1], w_res == '0, w_c, w_v};
      end
    end
  end
endmodule
